// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: button synchronise/debounce, start/stop/lap/clear FSM,
// and the 10 ms count-enable divider feeding the downstream counter.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV        = 1000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start,
  input  logic       btn_lap,
  output logic       tick_en,
  output logic       sw_clear,
  output logic       lap_hold,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_LAP  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  // Button index 0 = start, 1 = lap
  logic [1:0]         btn_raw;
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         lvl_q, lvl_d, lvl_prev_q;
  logic [1:0]         press_q, press_d;
  logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;

  logic [1:0]    state_q, state_d;
  logic          running_q, running_d;
  logic          lap_hold_q, lap_hold_d;
  logic          sw_clear_q, sw_clear_d;
  logic          tick_en_q, tick_en_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;

  assign btn_raw = {btn_lap, btn_start};

  // Debounce: a level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    lvl_d    = lvl_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          lvl_d[i] = ~lvl_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
    press_d = lvl_q & ~lvl_prev_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      press_q    <= '0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      press_q    <= press_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // Next state and registered outputs; a start press shadows a same-cycle lap press
  always_comb begin
    state_d    = state_q;
    sw_clear_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_q[0])      state_d = S_RUN;
        else if (press_q[1]) sw_clear_d = 1'b1;
      end
      S_RUN: begin
        if (press_q[0])      state_d = S_STOP;
        else if (press_q[1]) state_d = S_LAP;
      end
      S_LAP: begin
        if (press_q[0])      state_d = S_STOP;
        else if (press_q[1]) state_d = S_RUN;
      end
      S_STOP: begin
        if (press_q[0]) begin
          state_d = S_RUN;
        end else if (press_q[1]) begin
          state_d    = S_IDLE;
          sw_clear_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    running_d  = (state_d == S_RUN) || (state_d == S_LAP);
    lap_hold_d = (state_d == S_LAP);

    // Divider counts only across cycles that stay running, so STOP freezes the phase
    tick_cnt_d = tick_cnt_q;
    tick_en_d  = 1'b0;
    if (state_d == S_IDLE) begin
      tick_cnt_d = '0;
    end else if (running_q && running_d) begin
      if (tick_cnt_q == TICK_MAX) begin
        tick_cnt_d = '0;
        tick_en_d  = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
      sw_clear_q <= 1'b0;
      tick_en_q  <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      running_q  <= running_d;
      lap_hold_q <= lap_hold_d;
      sw_clear_q <= sw_clear_d;
      tick_en_q  <= tick_en_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign state    = state_q;
  assign running  = running_q;
  assign lap_hold = lap_hold_q;
  assign sw_clear = sw_clear_q;
  assign tick_en  = tick_en_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=10, DEBOUNCE_CYCLES=4.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic       tick_en, sw_clear, lap_hold, running;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  int n_tick = 0;
  int n_clr  = 0;
  int n_both = 0;
  int base;

  stopwatch_ctrl #(.TICK_DIV(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .tick_en   (tick_en),
    .sw_clear  (sw_clear),
    .lap_hold  (lap_hold),
    .running   (running),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled at each active edge
  always @(posedge clk) begin
    if (tick_en) n_tick <= n_tick + 1;
    if (sw_clear) n_clr <= n_clr + 1;
    if (tick_en && sw_clear) n_both <= n_both + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_running"}, 32'(running), 32'd0);
    chk({tag, "_lap_hold"}, 32'(lap_hold), 32'd0);
    chk({tag, "_sw_clear"}, 32'(sw_clear), 32'd0);
    chk({tag, "_tick_en"}, 32'(tick_en), 32'd0);
  endtask

  initial begin
    // 1: reset, then idle
    step(3);
    chk_all_zero("in_reset");
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    base = n_tick;
    step(100);
    chk_all_zero("idle");
    chk("idle_ticks", 32'(n_tick - base), 32'd0);

    // 3a: short bounce in IDLE produces no press
    btn_start = 1'b1;
    step(3);
    btn_start = 1'b0;
    step(20);
    chk("bounce_state", 32'(state), 32'd0);
    chk("bounce_ticks", 32'(n_tick - base), 32'd0);

    // 2: held start -> RUN at edge 8, ticks at 18, 28
    btn_start = 1'b1;
    step(7);
    chk("start_pre_state", 32'(state), 32'd0);
    step(1);
    chk("start_state", 32'(state), 32'd1);
    chk("start_running", 32'(running), 32'd1);
    step(9);
    chk("tick17", 32'(tick_en), 32'd0);
    step(1);
    chk("tick18", 32'(tick_en), 32'd1);
    step(1);
    chk("tick19", 32'(tick_en), 32'd0);
    step(1);
    btn_start = 1'b0;
    step(8);
    chk("tick28", 32'(tick_en), 32'd1);

    // 3b: simultaneous start+lap in RUN -> STOP only (divider frozen at 7)
    btn_start = 1'b1;
    btn_lap   = 1'b1;
    step(8);
    chk("both_state", 32'(state), 32'd3);
    chk("both_lap_hold", 32'(lap_hold), 32'd0);
    chk("both_sw_clear", 32'(sw_clear), 32'd0);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    base = n_tick;
    step(20);
    chk("both_hold_state", 32'(state), 32'd3);
    chk("stop_ticks_a", 32'(n_tick - base), 32'd0);

    // Resume from phase 7: ticks after counts 8, 9
    btn_start = 1'b1;
    step(8);
    chk("resume_a_state", 32'(state), 32'd1);
    btn_start = 1'b0;
    step(2);
    chk("resume_a_tick_early", 32'(tick_en), 32'd0);
    step(1);
    chk("resume_a_tick", 32'(tick_en), 32'd1);

    // 4: lap toggles lap_hold, ticking continues
    step(1);
    btn_lap = 1'b1;
    step(8);
    chk("lap_state", 32'(state), 32'd2);
    chk("lap_hold", 32'(lap_hold), 32'd1);
    chk("lap_running", 32'(running), 32'd1);
    step(1);
    chk("lap_tick21", 32'(tick_en), 32'd1);
    btn_lap = 1'b0;
    step(10);
    chk("lap_tick31", 32'(tick_en), 32'd1);
    btn_lap = 1'b1;
    step(8);
    chk("unlap_state", 32'(state), 32'd1);
    chk("unlap_hold", 32'(lap_hold), 32'd0);
    btn_lap = 1'b0;
    step(2);
    chk("unlap_tick41", 32'(tick_en), 32'd1);

    // 5: stop with divider at 6, 50 idle cycles, resume after counts 7, 8, 9
    step(9);
    btn_start = 1'b1;
    step(1);
    chk("tick51", 32'(tick_en), 32'd1);
    step(7);
    chk("stop6_state", 32'(state), 32'd3);
    chk("stop6_running", 32'(running), 32'd0);
    btn_start = 1'b0;
    base = n_tick;
    step(50);
    chk("stop_ticks_b", 32'(n_tick - base), 32'd0);
    btn_start = 1'b1;
    step(8);
    chk("resume_b_state", 32'(state), 32'd1);
    btn_start = 1'b0;
    step(3);
    chk("resume_b_tick_early", 32'(tick_en), 32'd0);
    step(1);
    chk("resume_b_tick", 32'(tick_en), 32'd1);
    step(9);
    chk("resume_b_tick_gap", 32'(tick_en), 32'd0);
    step(1);
    chk("resume_b_tick_next", 32'(tick_en), 32'd1);

    // 6: STOP then lap -> IDLE with one sw_clear pulse
    btn_start = 1'b1;
    step(8);
    chk("stop_c_state", 32'(state), 32'd3);
    btn_start = 1'b0;
    btn_lap   = 1'b1;
    base = n_clr;
    step(8);
    chk("clear_state", 32'(state), 32'd0);
    chk("clear_pulse", 32'(sw_clear), 32'd1);
    chk("clear_running", 32'(running), 32'd0);
    btn_lap = 1'b0;
    step(1);
    chk("clear_pulse_end", 32'(sw_clear), 32'd0);
    chk("clear_count", 32'(n_clr - base), 32'd1);

    // Divider was cleared: first tick exactly 10 cycles after entering RUN
    btn_start = 1'b1;
    step(8);
    chk("restart_state", 32'(state), 32'd1);
    btn_start = 1'b0;
    step(9);
    chk("restart_tick_early", 32'(tick_en), 32'd0);
    step(1);
    chk("restart_tick", 32'(tick_en), 32'd1);
    chk("restart_running", 32'(running), 32'd1);

    // Async reset mid-RUN while tick_en is high
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    base = n_tick;
    step(30);
    chk_all_zero("post_rst");
    chk("post_rst_ticks", 32'(n_tick - base), 32'd0);
    chk("tick_clear_overlap", 32'(n_both), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
